// File: rtl/dmem_pkg.sv
// Shared definitions for the block data memory: default geometry, access latency and FSM states.
package dmem_pkg;

    localparam int DMEM_ADDR_W  = 6;
    localparam int DMEM_DATA_W  = 32;
    localparam int DMEM_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Block storage: one write port, one registered read port, synchronous clear of every block.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_W,
    parameter int DATA_WIDTH = DMEM_DATA_W
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            rdata_d = '0;
        end else begin
            if (write_en) begin
                mem_d[addr] = wdata;
            end
            // Read port sees the pre-write contents; the top never enables both at once.
            if (read_en) begin
                rdata_d = mem_q[addr];
            end
        end
    end

    always_ff @(posedge clock) begin
        mem_q   <= mem_d;
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/block_data_memory.sv
// Block-addressed main memory answering the cache with a fixed-latency busywait handshake.
// Optional per-op completion counters are built when DMEM_ACCESS_COUNTERS_EN is defined.
module block_data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_W,
    parameter int DATA_WIDTH = DMEM_DATA_W,
    parameter int LATENCY    = DMEM_LATENCY
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
`ifdef DMEM_ACCESS_COUNTERS_EN
    output logic [15:0]           read_count,
    output logic [15:0]           write_count,
`endif
    output logic                  busywait
);

    if (LATENCY < 1) begin : g_bad_latency
        $error("block_data_memory: LATENCY must be at least 1");
    end

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dmem_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  is_write_q, is_write_d;
    logic                  access_done;

    assign access_done = (state_q == ACCESS) && (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        unique case (state_q)
            IDLE: begin
                if (read || write) begin
                    addr_d     = address;
                    wdata_d    = writedata;
                    is_write_d = write;
                    cnt_d      = CNT_LOAD;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (reset) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        is_write_q <= is_write_d;
    end

    assign busywait = !reset &&
                      (((state_q == IDLE) && (read || write)) || (state_q == ACCESS));

    // Array clear has priority over the commit, so a reset on the completion edge aborts it.
    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clock    (clock),
        .clear    (reset),
        .write_en (access_done && is_write_q),
        .read_en  (access_done && !is_write_q),
        .addr     (addr_q),
        .wdata    (wdata_q),
        .rdata    (readdata)
    );

`ifdef DMEM_ACCESS_COUNTERS_EN
    logic [15:0] read_count_q, read_count_d;
    logic [15:0] write_count_q, write_count_d;

    always_comb begin
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        if (access_done && !is_write_q && (read_count_q != 16'hFFFF)) begin
            read_count_d = read_count_q + 16'd1;
        end
        if (access_done && is_write_q && (write_count_q != 16'hFFFF)) begin
            write_count_d = write_count_q + 16'd1;
        end
        if (reset) begin
            read_count_d  = '0;
            write_count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        read_count_q  <= read_count_d;
        write_count_q <= write_count_d;
    end

    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// Scoreboard bench for block_data_memory: directed scenarios plus random traffic against an array model.
module tb_block_data_memory;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int LAT = 4;

    typedef struct {
        logic [DW-1:0] rdata;
        int            busy_cycles;
        string         name;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          busywait;
`ifdef DMEM_ACCESS_COUNTERS_EN
    logic [15:0]   read_count;
    logic [15:0]   write_count;
`endif

    int tests  = 0;
    int failed = 0;

    exp_t          sb_q[$];
    logic [DW-1:0] mem_m [1 << AW];
    logic [DW-1:0] last_rd;
    int            n_rd;
    int            n_wr;

    always #5 clock = ~clock;

    block_data_memory #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LATENCY    (LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
`ifdef DMEM_ACCESS_COUNTERS_EN
        .read_count  (read_count),
        .write_count (write_count),
`endif
        .busywait  (busywait)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each busywait fall outside reset is one completed access.
    int  busy_cnt = 0;
    logic busy_prev = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            busy_cnt  = 0;
            busy_prev = 1'b0;
        end else begin
            if (busywait) begin
                busy_cnt++;
            end else if (busy_prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_rdata"}, readdata, e.rdata);
                    check({e.name, "_latency"}, DW'(busy_cnt), DW'(e.busy_cycles));
                end
                busy_cnt = 0;
            end
            busy_prev = busywait;
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
        last_rd = '0;
        n_rd    = 0;
        n_wr    = 0;
    endfunction

    // Model of one access: writes win over reads and never disturb readdata.
    function automatic exp_t model_access(input logic rd, input logic wr,
                                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                                          input string name);
        exp_t e;
        if (wr) begin
            mem_m[a] = d;
            n_wr++;
        end else if (rd) begin
            last_rd = mem_m[a];
            n_rd++;
        end
        e.rdata       = last_rd;
        e.busy_cycles = LAT + 1;
        e.name        = name;
        return e;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // Issues a request and waits until the DONE cycle, where the request is dropped.
    task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input string name);
        bit done = 0;
        read      = rd;
        write     = wr;
        address   = a;
        writedata = d;
        sb_q.push_back(model_access(rd, wr, a, d, name));
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clock);
            if (!busywait) done = 1;
        end
        if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        address   = '0;
        writedata = '0;
        model_reset();

        // busywait stays low under reset even with a request present
        @(posedge clock);
        #1 read = 1'b1;
        @(negedge clock);
        check("busy_in_reset", DW'(busywait), 32'd0);
        read = 1'b0;
        do_reset();
        @(negedge clock);
        check("reset_readdata", readdata, 32'h0);
        check("reset_busy", DW'(busywait), 32'd0);
`ifdef DMEM_ACCESS_COUNTERS_EN
        check("reset_rcount", DW'(read_count), 32'd0);
        check("reset_wcount", DW'(write_count), 32'd0);
`endif
        idle(1);

        do_access(1, 0, 6'd5, '0, "read_after_reset");
        idle(2);
        do_access(0, 1, 6'd10, 32'hDEADBEEF, "write_10");
        idle(1);
        do_access(1, 0, 6'd10, '0, "read_10");
        idle(1);
        // back-to-back: the read is presented during DONE and starts in the following IDLE
        do_access(0, 1, 6'd63, 32'hA5A5A5A5, "b2b_write_63");
        do_access(1, 0, 6'd63, '0, "b2b_read_63");
        idle(1);
        do_access(1, 1, 6'd7, 32'h00FF00FF, "rw_both_7");
        idle(1);
        do_access(1, 0, 6'd7, '0, "read_7");
        idle(1);

        // reset in cycle 2 of a write aborts it
        write     = 1'b1;
        address   = 6'd3;
        writedata = 32'h12345678;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        write = 1'b0;
        @(negedge clock);
        check("abort_busy", DW'(busywait), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clock);
        check("abort_readdata", readdata, 32'h0);
`ifdef DMEM_ACCESS_COUNTERS_EN
        check("abort_rcount", DW'(read_count), 32'd0);
        check("abort_wcount", DW'(write_count), 32'd0);
`endif
        idle(1);
        do_access(1, 0, 6'd3, '0, "read_3_after_abort");
        idle(1);

        for (int i = 0; i < 40; i++) begin
            logic          rd, wr;
            logic [AW-1:0] a;
            int            op;
            op = $urandom_range(0, 9);
            rd = (op < 5) || (op == 9);
            wr = (op >= 5);
            a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 7));
            do_access(rd, wr, a, $urandom, "random");
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(3);
        check("scoreboard_empty", DW'(sb_q.size()), 32'd0);
`ifdef DMEM_ACCESS_COUNTERS_EN
        check("final_rcount", DW'(read_count), DW'(n_rd));
        check("final_wcount", DW'(write_count), DW'(n_wr));
        do_reset();
        @(negedge clock);
        check("post_reset_rcount", DW'(read_count), 32'd0);
        check("post_reset_wcount", DW'(write_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/block_data_memory.md
Name: block_data_memory

Overview:
- Block-addressed main data memory. It is the responder on the cache-to-memory interface: the cache drives read/write/address/writedata, and this block returns readdata and busywait.
- Holds 2^ADDR_WIDTH blocks of DATA_WIDTH bits and models a fixed multi-cycle access latency through a busywait handshake.
- Sits below the cache in the CPU memory hierarchy.

Parameters:
- ADDR_WIDTH, 6, block address width; the array depth is 64 blocks.
- DATA_WIDTH, 32, block width; one block holds four 8-bit words.
- LATENCY, 4, clock cycles from accept to completion. Must be ≥1; elaboration fails for 0.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- read  input  1  block read request; held until completion.
- write  input  1  block write request; held until completion.
- address  input  ADDR_WIDTH  block address; sampled at accept.
- writedata  input  DATA_WIDTH  block write data; sampled at accept.
- readdata  output  DATA_WIDTH  registered read result; valid from the completion edge.
- busywait  output  1  high while a request is pending or in progress.

Behaviour:
- Reset (sampled at posedge, synchronous, active-high):
  - All array blocks cleared to 0; readdata = 0; state = IDLE; latency counter = 0.
  - busywait = 0 while reset is high, regardless of read/write.
  - Reset during an access aborts it. No write is committed and readdata is unchanged apart from being cleared to 0.
- States: IDLE, ACCESS, DONE.
- busywait (combinational): 1 when (state==IDLE and (read|write)) or state==ACCESS; otherwise 0. It is 0 in DONE.
- IDLE:
  - On a posedge with read|write high, latch address, writedata and op (write has priority if both are high).
  - Load counter = LATENCY-1 and go to ACCESS.
- ACCESS:
  - Counter decrements each posedge.
  - On the posedge where the counter is 0:
    - Write: mem[latched addr] <= latched data.
    - Read: readdata <= mem[latched addr].
    - Go to DONE.
  - Request inputs are ignored (not re-sampled) during ACCESS.
- DONE: one cycle with busywait = 0. The initiator samples completion at the next posedge, and the state returns to IDLE.
- Latency: request asserted in cycle 0 → busywait low in cycle LATENCY+1 → readdata valid from the same edge. Total occupancy is LATENCY+2 cycles including DONE.
- Back-to-back accesses: if read|write is still high in IDLE after DONE, it is treated as a new access. The initiator must drop its request on the completion edge.
- Both read and write high: performed as a write; readdata is not updated.
- Address wrap: none; every address in 0..2^ADDR_WIDTH-1 is valid.
- readdata holds its last value between reads. Writes never change readdata.

Optional Feature:
- Macro: DMEM_ACCESS_COUNTERS_EN.
- With the macro:
  - Adds output ports read_count[15:0] and write_count[15:0].
  - Each increments on the completion edge of its op and saturates at 16'hFFFF.
  - Both clear on reset.
- Without the macro: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package dmem_pkg holds:
  - DMEM_ADDR_W = 6, DMEM_DATA_W = 32 and the default DMEM_LATENCY = 4.
  - The state enum (IDLE, ACCESS, DONE).
- One natural sub-module, dmem_array: the synchronous storage with a single write port, a registered read port and a synchronous clear.
- The FSM, latency counter and optional counters stay in the top module.

Test Plan:
- Reset then read: read with address 6'd5 → busywait is 1 for 5 cycles (cycles 0–4, LATENCY=4), readdata = 32'h0, busywait = 0 in cycle 5.
- Write then read back: write address 6'd10, data 32'hDEADBEEF; after completion, read address 6'd10 → readdata = 32'hDEADBEEF. The write leaves readdata unchanged.
- Back-to-back: write address 6'd63, data 32'hA5A5A5A5, immediately followed by read address 6'd63 → the second access begins the cycle after DONE; readdata = 32'hA5A5A5A5; no lost or duplicated access.
- Reset mid-write: write address 6'd3, data 32'h12345678; assert reset in cycle 2 → busywait = 0; a later read of address 6'd3 returns 32'h0.
- Simultaneous read and write to address 6'd7, data 32'h00FF00FF → treated as a write; readdata is unchanged; a later read returns 32'h00FF00FF.
- With DMEM_ACCESS_COUNTERS_EN: 3 reads and 2 writes → read_count = 3, write_count = 2; reset → both 0.
